// File: rtl/sms4_key_sched_if.sv
// Key schedule bus: master key load, delivery-pointer control and round key readout.
// Bit ranges stay big-endian so that word 0 of the master key occupies bits [0:31].
interface sms4_key_sched_if #(
    parameter int KWIDTH = 128,
    parameter int RWIDTH = 32
);
    logic [0:KWIDTH-1] key_in;
    logic              key_load;
    logic              mode;
    logic              rk_start;
    logic              rk_next;
    logic [0:RWIDTH-1] round_key;
    logic [0:4]        round_idx;
    logic              key_busy;
    logic              key_ready;

    modport master (
        output key_in, key_load, mode, rk_start, rk_next,
        input  round_key, round_idx, key_busy, key_ready
    );

    modport slave (
        input  key_in, key_load, mode, rk_start, rk_next,
        output round_key, round_idx, key_busy, key_ready
    );
endinterface

// File: rtl/sms4_key_sched.sv
// SMS4 key expansion: one round key per clock into a 32-entry store, then
// delivered through a pointer that walks forward (encrypt) or backward (decrypt).
module ARS_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign dout = SBOX[din];
endmodule

module sms4_key_sched #(
    parameter int KWIDTH = 128,
    parameter int RWIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    sms4_key_sched_if.slave    bus
);
    localparam int NWORDS = KWIDTH / RWIDTH;

    localparam logic [RWIDTH-1:0] FK [4] = '{
        32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_t;

    state_t            state;
    logic [4:0]        cnt;
    logic [4:0]        ptr;
    logic              mode_r;
    logic              busy_r;
    logic              ready_r;
    logic [RWIDTH-1:0] wk    [4];
    logic [RWIDTH-1:0] store [32];

    logic [RWIDTH-1:0] ck;
    logic [RWIDTH-1:0] sx;
    logic [RWIDTH-1:0] tx;
    logic [RWIDTH-1:0] rk;
    logic [7:0]        ck_base;

    // CK byte j of round i is (4i+j)*7 mod 256, so only the byte offset varies.
    always_comb begin
        ck_base      = {1'b0, cnt, 2'b00};
        ck[31:24]    = ck_base * 8'd7;
        ck[23:16]    = (ck_base + 8'd1) * 8'd7;
        ck[15:8]     = (ck_base + 8'd2) * 8'd7;
        ck[7:0]      = (ck_base + 8'd3) * 8'd7;
    end

    assign sx = wk[1] ^ wk[2] ^ wk[3] ^ ck;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        ARS_sbox u_sbox (
            .din  (sx[8*g +: 8]),
            .dout (tx[8*g +: 8])
        );
    end

    assign rk = wk[0] ^ tx
              ^ {tx[RWIDTH-14:0], tx[RWIDTH-1:RWIDTH-13]}
              ^ {tx[RWIDTH-24:0], tx[RWIDTH-1:RWIDTH-23]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            mode_r  <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) wk[i] <= '0;
            for (int unsigned i = 0; i < 32; i++) store[i] <= '0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (bus.key_load) begin
                        for (int unsigned j = 0; j < NWORDS; j++)
                            wk[j] <= bus.key_in[j*RWIDTH +: RWIDTH] ^ FK[j];
                        cnt     <= '0;
                        state   <= EXPAND;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end
                end
                EXPAND: begin
                    store[cnt] <= rk;
                    wk[0]      <= wk[1];
                    wk[1]      <= wk[2];
                    wk[2]      <= wk[3];
                    wk[3]      <= rk;
                    cnt        <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state   <= READY;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Pointer control runs off the current state, so a reload and a
            // pointer request in the same READY cycle are both honoured.
            if (state == READY) begin
                if (bus.rk_start) begin
                    mode_r <= bus.mode;
                    ptr    <= bus.mode ? 5'd31 : 5'd0;
                end else if (bus.rk_next) begin
                    ptr <= mode_r ? ptr - 5'd1 : ptr + 5'd1;
                end
            end
        end
    end

    assign bus.key_busy  = busy_r;
    assign bus.key_ready = ready_r;
    assign bus.round_idx = ptr;
    assign bus.round_key = store[ptr];
endmodule

// File: tb/tb_sms4_key_sched.sv
// Bench for sms4_key_sched: vector table and scoreboard for key delivery,
// hand sequences for latency, reload-while-busy, pointer wrap and mid-run reset.
module tb_sms4_key_sched;
    localparam logic [127:0] MK   = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [31:0]  RK0  = 32'hF12186F9;
    localparam logic [31:0]  RK1  = 32'h41662B61;
    localparam logic [31:0]  RK31 = 32'h9124A012;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sms4_key_sched_if #(.KWIDTH(128), .RWIDTH(32)) bus ();

    sms4_key_sched #(.KWIDTH(128), .RWIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic [4:0]  idx;
        bit          chk_key;
        logic [31:0] key;
    } exp_t;

    typedef struct {
        bit          s;
        bit          n;
        bit          m;
        logic [4:0]  idx;
        bit          chk_key;
        logic [31:0] key;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[10];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_sample();
        exp_t e;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sbq.pop_front();
            check32({e.name, " idx"}, 32'(bus.round_idx), 32'(e.idx));
            if (e.chk_key) check32({e.name, " key"}, 32'(bus.round_key), e.key);
        end
    endtask

    task automatic step(input string name, input bit s, input bit n, input bit m,
                        input logic [4:0] idx, input bit ck, input logic [31:0] key);
        @(negedge clk);
        bus.rk_start = s;
        bus.rk_next  = n;
        bus.mode     = m;
        sbq.push_back('{name, idx, ck, key});
        @(posedge clk);
        #1;
        bus.rk_start = 1'b0;
        bus.rk_next  = 1'b0;
        sb_sample();
    endtask

    task automatic load_key(input logic [127:0] k);
        @(negedge clk);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        @(posedge clk);
        #1;
        bus.key_load = 1'b0;
    endtask

    // Entered just after the edge that accepted key_load; counts edges until key_ready.
    task automatic wait_ready(input string name, input int reload_at, input bit chk_ck);
        int lat = 0;
        int bad_busy = 0;
        check32({name, " busy after load"}, 32'(bus.key_busy), 32'd1);
        check32({name, " ready after load"}, 32'(bus.key_ready), 32'd0);
        while (!bus.key_ready && lat < 100) begin
            if (bus.key_busy !== 1'b1) bad_busy++;
            if (chk_ck && lat == 0)  check32("CK0", dut.ck, 32'h00070E15);
            if (chk_ck && lat == 1)  check32("CK1", dut.ck, 32'h1C232A31);
            if (chk_ck && lat == 31) check32("CK31", dut.ck, 32'h646B7279);
            if (lat == reload_at) begin
                @(negedge clk);
                bus.key_in   = '1;
                bus.key_load = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.key_load = 1'b0;
            lat++;
        end
        check32({name, " edges to ready"}, 32'(lat), 32'd32);
        check32({name, " busy drops"}, 32'(bad_busy), 32'd0);
        check32({name, " busy at ready"}, 32'(bus.key_busy), 32'd0);
    endtask

    initial begin
        bus.key_in   = '0;
        bus.key_load = 1'b0;
        bus.mode     = 1'b0;
        bus.rk_start = 1'b0;
        bus.rk_next  = 1'b0;

        vt[0] = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b1, RK0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 5'd1,  1'b1, RK1};
        vt[2] = '{1'b0, 1'b1, 1'b1, 5'd2,  1'b0, 32'h0};
        vt[3] = '{1'b1, 1'b0, 1'b1, 5'd31, 1'b1, RK31};
        vt[4] = '{1'b0, 1'b1, 1'b0, 5'd30, 1'b0, 32'h0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 5'd0,  1'b1, RK0};
        vt[6] = '{1'b0, 1'b1, 1'b1, 5'd1,  1'b1, RK1};
        vt[7] = '{1'b0, 1'b0, 1'b1, 5'd1,  1'b1, RK1};
        vt[8] = '{1'b1, 1'b1, 1'b1, 5'd31, 1'b1, RK31};
        vt[9] = '{1'b0, 1'b1, 1'b0, 5'd30, 1'b0, 32'h0};

        #12;
        check32("reset busy", 32'(bus.key_busy), 32'd0);
        check32("reset ready", 32'(bus.key_ready), 32'd0);
        check32("reset idx", 32'(bus.round_idx), 32'd0);
        check32("reset key", 32'(bus.round_key), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Pointer requests outside READY must not move the pointer.
        step("idle start", 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 32'h0);
        step("idle next",  1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0);

        load_key(MK);
        wait_ready("exp1", -1, 1'b1);

        for (int i = 0; i < 10; i++)
            step($sformatf("vec%0d", i), vt[i].s, vt[i].n, vt[i].m, vt[i].idx, vt[i].chk_key, vt[i].key);

        step("dec start", 1'b1, 1'b0, 1'b1, 5'd31, 1'b1, RK31);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] e;
            e = 5'(30 - i);
            step($sformatf("dec wrap%0d", i), 1'b0, 1'b1, 1'b0, e, (i == 31), RK31);
        end

        step("enc start", 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, RK0);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] e;
            e = 5'(i + 1);
            step($sformatf("enc wrap%0d", i), 1'b0, 1'b1, 1'b1, e,
                 (i == 30) || (i == 31), (i == 31) ? RK0 : RK31);
        end

        // Restart from READY, with a second key_load landing mid-expansion.
        load_key(MK);
        wait_ready("exp2", 9, 1'b0);
        step("exp2 enc", 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, RK0);
        step("exp2 nxt", 1'b0, 1'b1, 1'b0, 5'd1,  1'b1, RK1);
        step("exp2 dec", 1'b1, 1'b0, 1'b1, 5'd31, 1'b1, RK31);

        load_key(MK);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        check32("midreset busy", 32'(bus.key_busy), 32'd0);
        check32("midreset ready", 32'(bus.key_ready), 32'd0);
        check32("midreset idx", 32'(bus.round_idx), 32'd0);
        check32("midreset key", 32'(bus.round_key), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        load_key(MK);
        wait_ready("exp3", -1, 1'b1);
        step("exp3 enc", 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, RK0);
        step("exp3 dec", 1'b1, 1'b0, 1'b1, 5'd31, 1'b1, RK31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sms4_key_sched.md
SMS4_KEY_SCHED -- requirements
Module: sms4_key_sched

Interface
REQ-001 The module SHALL have parameter KWIDTH, default 128, meaning master key width.
REQ-002 The module SHALL have parameter RWIDTH, default 32, meaning round key width.
REQ-003 The module SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, asynchronous, active-low reset.
REQ-005 The module SHALL have port key_in, input, [0:KWIDTH-1], the master key MK with MK0 in bits [0:31].
REQ-006 The module SHALL have port key_load, input, 1 bit, a request to start expansion of key_in.
REQ-007 The module SHALL have port mode, input, 1 bit, the delivery order: 0 = encrypt (rk0 to rk31), 1 = decrypt (rk31 to rk0).
REQ-008 The module SHALL have port rk_start, input, 1 bit, which sets the delivery pointer to the first key for mode.
REQ-009 The module SHALL have port rk_next, input, 1 bit, which advances the delivery pointer by one.
REQ-010 The module SHALL have port round_key, output, [0:RWIDTH-1], the stored key at the pointer, taken combinationally from storage.
REQ-011 The module SHALL have port round_idx, output, [0:4], the current pointer value.
REQ-012 The module SHALL have port key_busy, output, 1 bit, high during expansion.
REQ-013 The module SHALL have port key_ready, output, 1 bit, high when all 32 round keys are valid.

Function
REQ-014 FSM states SHALL be IDLE, EXPAND and READY, with IDLE as the reset state.
REQ-015 Transitions SHALL be: IDLE or READY with key_load goes to EXPAND; EXPAND with counter 31 goes to READY; otherwise the state holds.
REQ-016 On accepted key_load, the block SHALL load working words K0..K3 = MK0..MK3 XOR FK, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
REQ-017 Each EXPAND cycle i (0..31) SHALL compute rk_i = K0 ^ L'(tau(K1^K2^K3^CK_i)), write it to storage slot i, and shift K0..K3 to K1, K2, K3, rk_i.
REQ-018 tau SHALL be four parallel instances of the team SMS4 S-box (ARS_sbox), one per byte; L'(B) = B ^ (B<<<13) ^ (B<<<23).
REQ-019 Byte j (0..3, MSB first) of CK_i SHALL be ((4i+j)*7) mod 256, generated from the 5-bit counter by logic or a 32-entry constant table.
REQ-020 Latency: key_load sampled high at edge N SHALL give key_busy=1 for edges N+1..N+32, and key_ready=1 from edge N+33.
REQ-021 key_load SHALL be ignored while in EXPAND.
REQ-022 key_load while in READY SHALL restart expansion and drop key_ready at the next edge.
REQ-023 Storage SHALL be 32 x RWIDTH registers, written only in EXPAND.
REQ-024 rk_start SHALL set the pointer to 0 when mode=0 and to 31 when mode=1.
REQ-025 rk_next SHALL increment the pointer when mode=0 and decrement it when mode=1, with modulo-32 wrap (31 goes to 0, 0 goes to 31).
REQ-026 When rk_start and rk_next are high in the same cycle, rk_start SHALL win.
REQ-027 rk_start and rk_next SHALL be ignored unless the state is READY.
REQ-028 mode SHALL be sampled only on rk_start.
REQ-029 round_key contents SHALL be don't-care while key_ready=0.

Reset
REQ-030 Reset low SHALL asynchronously force the state to IDLE, counter=0, pointer=0, and all working and storage registers to 0.
REQ-031 After reset, outputs SHALL be key_busy=0, key_ready=0, round_idx=0, round_key=00000000.
REQ-032 Reset asserted mid-EXPAND SHALL abort expansion, with no partial key_ready.

Verification
REQ-033 MK=0123456789ABCDEFFEDCBA9876543210, key_load pulse, then rk_start with mode=0 -> key_ready at N+33, round_key=F12186F9, and after one rk_next round_key=41662B61.
REQ-034 Same key, rk_start with mode=1 -> round_idx=31, round_key=9124A012; after 32 rk_next pulses the pointer wraps back to 31.
REQ-035 key_load pulsed again at cycle N+10 of an expansion -> ignored; key_ready still rises at N+33 with the first key's values.
REQ-036 rk_start and rk_next asserted together with mode=0 -> round_idx=0.
REQ-037 Reset pulsed at cycle N+15 -> key_busy=0 and key_ready=0 immediately; a following key_load completes normally after 33 cycles.
REQ-038 Check CK generation: CK0=00070E15, CK1=1C232A31, CK31=646B7279.
